// File: rtl/a2d_spi_resp_if.sv
`default_nettype none
// ============================================================================
// Module      : a2d_spi_resp_if
// Description : Four-wire SPI link between the A2D master and the responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface a2d_spi_resp_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface
`default_nettype wire

// File: rtl/a2d_spi_resp.sv
`default_nettype none
// ============================================================================
// Module      : a2d_spi_resp
// Description : 8-channel 12-bit A2D SPI emulator; each frame returns the
//               channel addressed by the previous complete frame.
// Revision    : 1.0 - initial release
// ============================================================================
module a2d_spi_resp #(
    parameter logic [2:0] RST_CHAN = 3'd0,
    parameter int         CH_W     = 12
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    a2d_spi_resp_if.slave          spi,
    input  wire logic [8*CH_W-1:0] chan_vals,
    output logic [2:0]             ch_sel,
    output logic [15:0]            last_cmd,
    output logic                   cmd_vld,
    output logic                   frame_err
);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_SHIFT = 1'b1;

    logic [2:0]      r_ss_sync;
    logic [2:0]      r_sclk_sync;
    logic [1:0]      r_mosi_sync;
    logic [0:0]      r_state;
    logic [15:0]     r_tx_shft;
    logic [15:0]     r_rx_shft;
    logic [4:0]      r_bit_cnt;
    logic [CH_W-1:0] w_chan [8];
    logic            w_ss_fall;
    logic            w_ss_rise;
    logic            w_sclk_rise;
    logic            w_sclk_fall;

    generate
        for (genvar g = 0; g < 8; g++) begin : g_chan
            assign w_chan[g] = chan_vals[g*CH_W +: CH_W];
        end
    endgenerate

    // Bit [1] is the synchronized level, bit [2] the previous one for edges;
    // MOSI taps bit [1] so it lines up with the SCLK edge it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ss_sync   <= 3'b111;
            r_sclk_sync <= 3'b111;
            r_mosi_sync <= 2'b00;
        end else begin
            r_ss_sync   <= {r_ss_sync[1:0], spi.SS_n};
            r_sclk_sync <= {r_sclk_sync[1:0], spi.SCLK};
            r_mosi_sync <= {r_mosi_sync[0], spi.MOSI};
        end
    end

    assign w_ss_fall   =  r_ss_sync[2]   & ~r_ss_sync[1];
    assign w_ss_rise   = ~r_ss_sync[2]   &  r_ss_sync[1];
    assign w_sclk_rise = ~r_sclk_sync[2] &  r_sclk_sync[1];
    assign w_sclk_fall =  r_sclk_sync[2] & ~r_sclk_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_tx_shft <= 16'h0000;
            r_rx_shft <= 16'h0000;
            r_bit_cnt <= 5'd0;
            ch_sel    <= RST_CHAN;
            last_cmd  <= 16'h0000;
            cmd_vld   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cmd_vld   <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_ss_fall) begin
                        r_tx_shft <= 16'(w_chan[ch_sel]);
                        r_rx_shft <= 16'h0000;
                        r_bit_cnt <= 5'd0;
                        r_state   <= c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    // Frame end takes priority over any coincident SCLK edge.
                    if (w_ss_rise) begin
                        if (r_bit_cnt == 5'd16) begin
                            last_cmd <= r_rx_shft;
                            ch_sel   <= r_rx_shft[13:11];
                            cmd_vld  <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        r_state <= c_IDLE;
                    end else begin
                        if (w_sclk_rise) begin
                            r_rx_shft <= {r_rx_shft[14:0], r_mosi_sync[1]};
                            if (r_bit_cnt != 5'd31) begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                        // The leading fall precedes the first rise; bit 15 must hold.
                        if (w_sclk_fall && (r_bit_cnt != 5'd0)) begin
                            r_tx_shft <= {r_tx_shft[14:0], 1'b0};
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign spi.MISO = (r_state == c_SHIFT) & r_tx_shft[15];

endmodule
`default_nettype wire

// File: tb/tb_a2d_spi_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_a2d_spi_resp
// Description : Scoreboard bench for a2d_spi_resp driving directed SPI frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_a2d_spi_resp;
    localparam int         CH_W     = 12;
    localparam logic [2:0] RST_CHAN = 3'd0;

    logic              clk;
    logic              rst_n;
    logic [8*CH_W-1:0] chan_vals;
    logic [2:0]        ch_sel;
    logic [15:0]       last_cmd;
    logic              cmd_vld;
    logic              frame_err;

    a2d_spi_resp_if sif ();

    a2d_spi_resp #(.RST_CHAN(RST_CHAN), .CH_W(CH_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi       (sif.slave),
        .chan_vals (chan_vals),
        .ch_sel    (ch_sel),
        .last_cmd  (last_cmd),
        .cmd_vld   (cmd_vld),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        bit          chk_miso;
        logic [15:0] miso;
        logic [2:0]  ch_sel;
        logic [15:0] last_cmd;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] cap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input bit e, input bit cm, input logic [15:0] m,
                        input logic [2:0] c, input logic [15:0] l);
        exp_t x;
        x.is_err = e; x.chk_miso = cm; x.miso = m; x.ch_sel = c; x.last_cmd = l;
        sbq.push_back(x);
    endtask

    // MISO is sampled by the master on each SCLK rise inside a frame.
    always @(negedge sif.SS_n) cap = 16'h0000;
    always @(posedge sif.SCLK) if (sif.SS_n === 1'b0) cap = {cap[14:0], sif.MISO};

    always @(negedge clk) begin
        if (rst_n === 1'b1 && (cmd_vld === 1'b1 || frame_err === 1'b1)) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got vld=%b err=%b expected none", cmd_vld, frame_err);
            end else begin
                exp_t x;
                x = sbq.pop_front();
                chk("pulse_kind", {cmd_vld, frame_err}, {~x.is_err, x.is_err});
                if (x.chk_miso) chk("miso_word", cap, x.miso);
                chk("ch_sel", ch_sel, x.ch_sel);
                chk("last_cmd", last_cmd, x.last_cmd);
            end
        end
    end

    // rises: SCLK rise count; chg_bit: rise index where ch5 becomes AAA;
    // rst_bit: rise index where rst_n is pulsed and the frame abandoned.
    task automatic spi_frame(input logic [15:0] cmd, input int rises,
                             input int chg_bit, input int rst_bit);
        sif.SS_n = 1'b0;
        wclk(8);
        for (int i = 0; i < rises; i++) begin
            if (i == rst_bit) begin
                rst_n = 1'b0;
                wclk(2);
                chk("rst_ch_sel", ch_sel, RST_CHAN);
                chk("rst_miso", sif.MISO, 0);
                chk("rst_cmd_vld", cmd_vld, 0);
                sif.SS_n = 1'b1; sif.SCLK = 1'b1; sif.MOSI = 1'b0;
                wclk(4);
                rst_n = 1'b1;
                wclk(4);
                return;
            end
            if (i == chg_bit) chan_vals[5*CH_W +: CH_W] = 12'hAAA;
            sif.SCLK = 1'b0;
            sif.MOSI = (i < 16) ? cmd[15-i] : 1'b0;
            wclk(8);
            sif.SCLK = 1'b1;
            wclk(8);
        end
        sif.SS_n = 1'b1;
        sif.MOSI = 1'b0;
        wclk(10);
    endtask

    initial begin
        rst_n = 1'b0;
        sif.SS_n = 1'b1; sif.SCLK = 1'b1; sif.MOSI = 1'b0;
        chan_vals = {12'h777, 12'h666, 12'h555, 12'hFFF, 12'h333, 12'h222, 12'h123, 12'hABC};
        wclk(3);
        chk("reset_miso", sif.MISO, 0);
        chk("reset_ch_sel", ch_sel, RST_CHAN);
        chk("reset_last_cmd", last_cmd, 0);
        chk("reset_cmd_vld", cmd_vld, 0);
        chk("reset_frame_err", frame_err, 0);
        rst_n = 1'b1;
        wclk(4);

        push(0, 1, 16'h0ABC, 3'd1, 16'h0800); spi_frame(16'h0800, 16, -1, -1);
        push(0, 1, 16'h0123, 3'd4, 16'h2000); spi_frame(16'h2000, 16, -1, -1);
        push(0, 1, 16'h0FFF, 3'd0, 16'h0000); spi_frame(16'h0000, 16, -1, -1);
        push(0, 1, 16'h0ABC, 3'd5, 16'h2800); spi_frame(16'h2800, 16, -1, -1);
        // Channel 5 changes mid-frame; the snapshot must still be returned.
        push(0, 1, 16'h0555, 3'd2, 16'h1000); spi_frame(16'h1000, 16, 8, -1);
        push(1, 0, 16'h0000, 3'd2, 16'h1000); spi_frame(16'hFFFF, 9, -1, -1);
        push(1, 0, 16'h0000, 3'd2, 16'h1000); spi_frame(16'h3800, 17, -1, -1);

        for (int k = 0; k < 5; k++) begin
            sif.SCLK = 1'b0; sif.MOSI = k[0];
            wclk(8);
            sif.SCLK = 1'b1;
            wclk(8);
        end
        sif.MOSI = 1'b0;
        chk("idle_ch_sel", ch_sel, 3'd2);
        chk("idle_last_cmd", last_cmd, 16'h1000);
        push(0, 1, 16'h0222, 3'd1, 16'h0800); spi_frame(16'h0800, 16, -1, -1);

        spi_frame(16'h3800, 16, -1, 10);
        push(0, 1, 16'h0ABC, 3'd0, 16'h0000); spi_frame(16'h0000, 16, -1, -1);

        wclk(20);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/a2d_spi_resp.md
Name: a2d_spi_resp

Overview:
- Synthesizable SPI responder that emulates the 8-channel, 12-bit A2D on the far end of the A2D SPI link.
- Receives 16-bit command frames from the SPI master on MOSI and returns conversion data on MISO.
- Follows the A2D's pipelined protocol: each frame returns the value of the channel addressed by the previous valid frame.
- Used as the A2D stand-in in full-chip sims and on FPGA bring-up, fed by stimulus or test registers through chan_vals.

Parameters:
- RST_CHAN, 3'd0, channel returned by the first frame after reset.
- CH_W, 12, width of each channel value; response is zero-padded to 16 bits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- SS_n  in  1  slave select from master, active low, asynchronous to clk
- SCLK  in  1  serial clock from master, idles high, asynchronous to clk
- MOSI  in  1  command bits from master, MSB first
- MISO  out  1  response bits to master, MSB first
- chan_vals  in  8*CH_W  channel values; channel n occupies [n*CH_W +: CH_W]
- ch_sel  out  3  channel that the next frame will return
- last_cmd  out  16  last complete command frame received
- cmd_vld  out  1  one-clk pulse when a complete 16-bit frame ends
- frame_err  out  1  one-clk pulse when a frame ends with a bit count other than 16

Behaviour:
- Synchronizers: SS_n, SCLK and MOSI each pass through 2 flops, plus a 3rd flop on SS_n and SCLK for edge detect.
  - Reset values: SS_n and SCLK chains = 1, MOSI chain = 0.
  - All edge events use the synchronized signals, so MOSI and SCLK share the same latency.
- Reset values: MISO=0, ch_sel=RST_CHAN, last_cmd=16'h0000, cmd_vld=0, frame_err=0, bit_cnt=0, state=IDLE.
- State machine, 2 states: IDLE and SHIFT.
- IDLE:
  - SCLK edges are ignored.
  - On synchronized SS_n fall: tx_shft <= {(16-CH_W) zeros, chan_vals[ch_sel]}, rx_shft <= 0, bit_cnt <= 0, go to SHIFT.
  - The channel value is snapshotted at frame start. Later changes to chan_vals do not affect the frame in progress.
- SHIFT:
  - SCLK rise: rx_shft <= {rx_shft[14:0], MOSI_sync}; bit_cnt increments (5 bits, saturates at 31).
  - SCLK fall with bit_cnt != 0: tx_shft <= {tx_shft[14:0], 1'b0}.
  - SCLK fall with bit_cnt == 0: this is the master's leading fall and does not shift. Bit 15 must stay valid for the first rise.
  - SS_n rise with bit_cnt == 16: last_cmd <= rx_shft, ch_sel <= rx_shft[13:11], cmd_vld pulses 1 clk, go to IDLE.
  - SS_n rise with bit_cnt != 16: ch_sel and last_cmd are unchanged, frame_err pulses 1 clk, go to IDLE.
- MISO = tx_shft[15] while state==SHIFT, 0 in IDLE (combinational from state and the register).
- Response latency: data for channel N is returned in the frame after the frame that carried channel N in bits [13:11]. The remaining command bits are stored in last_cmd but otherwise ignored.
- Simultaneous SS_n rise and SCLK edge in one clk: SS_n wins; the edge is ignored and bit_cnt is not updated.
- SS_n fall in SHIFT: cannot occur without an intervening rise; no special handling.
- Async reset mid-frame: immediate return to reset values. A partial frame is discarded with no pulse.
- Master constraint: SCLK period ≥ 8 clk and SS_n setup/hold ≥ 4 clk, to cover synchronizer latency.

Test Plan:
- Reset, chan_vals[0]=12'hABC, frame with cmd 16'h0800 → MISO returns 16'h0ABC; cmd_vld pulses; ch_sel=1; last_cmd=16'h0800.
- chan_vals[1]=12'h123, frame with cmd 16'h2000 → returns 16'h0123; ch_sel=4. Next frame with cmd 16'h0000 and chan4=12'hFFF → returns 16'h0FFF; ch_sel=0.
- Change chan_vals[ch_sel] from 12'h555 to 12'hAAA at bit 8 of a frame → full frame returns 16'h0555.
- Abort SS_n after 9 SCLK rises, then after 17 rises → frame_err pulses each time; cmd_vld stays 0; ch_sel and last_cmd unchanged.
- Toggle SCLK with SS_n high, then run a valid frame → no state change from the idle toggling; valid frame behaves normally.
- Assert rst_n low at bit 10 of a frame with cmd 16'h3800 → ch_sel=RST_CHAN, MISO=0; the next frame returns chan_vals[RST_CHAN].
